// File: rtl/spi_slave_pkg.sv
// rtl/spi_slave_pkg.sv - shared types and constants for the SPI nibble receiver
package spi_slave_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} spi_state_t;

  localparam logic [3:0] CMD_WR_DEFAULT = 4'hA;
  localparam int         BYTE_W         = 8;

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - one-bit multi-flop synchroniser with configurable reset value
module sync_ff #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {DEPTH{RST_VAL}};
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], d_i};
    end
  end

  assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/spi_slave_nibble_rx.sv
// rtl/spi_slave_nibble_rx.sv - SPI mode-0 slave byte receiver holding a 4-bit display code
// Optional MISO echo of the last accepted byte is built when MISO_ECHO_EN is defined.
module spi_slave_nibble_rx
  import spi_slave_pkg::*;
#(
  parameter logic [3:0] CMD_WR  = CMD_WR_DEFAULT,
  parameter int         SYNC_FF = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       cs_n,
  output logic       miso,
  output logic [3:0] nibble,
  output logic       byte_valid,
  output logic       cmd_err,
  output logic       frame_err
);

  logic sclk_s, mosi_s, csn_s;

  sync_ff #(.DEPTH(SYNC_FF), .RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst(rst), .d_i(sclk), .q_o(sclk_s));
  sync_ff #(.DEPTH(SYNC_FF), .RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .d_i(mosi), .q_o(mosi_s));
  sync_ff #(.DEPTH(SYNC_FF), .RST_VAL(1'b1)) u_sync_csn  (.clk(clk), .rst(rst), .d_i(cs_n), .q_o(csn_s));

  spi_state_t        state_q;
  logic              sclk_d1_q, csn_d1_q;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [3:0]        nibble_q;
  logic              byte_valid_q, cmd_err_q, frame_err_q;
  logic              sclk_rise, csn_fall, accept, last_bit;

  assign sclk_rise = sclk_s & ~sclk_d1_q;
  assign csn_fall  = ~csn_s & csn_d1_q;
  assign shift_d   = {shift_q[BYTE_W-2:0], mosi_s};
  assign bit_cnt_d = bit_cnt_q + 3'd1;
  assign accept    = (shift_q[BYTE_W-1:4] == CMD_WR);
  assign last_bit  = (bit_cnt_q == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sclk_d1_q    <= 1'b0;
      csn_d1_q     <= 1'b1;
      shift_q      <= '0;
      bit_cnt_q    <= 3'd0;
      nibble_q     <= 4'h0;
      byte_valid_q <= 1'b0;
      cmd_err_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sclk_d1_q    <= sclk_s;
      csn_d1_q     <= csn_s;
      byte_valid_q <= 1'b0;
      cmd_err_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (csn_fall) begin
            bit_cnt_q <= 3'd0;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          // An 8th edge coinciding with cs_n rising still completes the byte.
          if (sclk_rise && (!csn_s || last_bit)) begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            if (last_bit) state_q <= DONE;
          end else if (csn_s) begin
            frame_err_q <= (bit_cnt_q != 3'd0);
            bit_cnt_q   <= 3'd0;
            shift_q     <= '0;
            state_q     <= IDLE;
          end
        end
        DONE: begin
          byte_valid_q <= 1'b1;
          if (accept) nibble_q  <= shift_q[3:0];
          else        cmd_err_q <= 1'b1;
          state_q <= csn_s ? IDLE : SHIFT;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign nibble     = nibble_q;
  assign byte_valid = byte_valid_q;
  assign cmd_err    = cmd_err_q;
  assign frame_err  = frame_err_q;

`ifdef MISO_ECHO_EN
  logic [BYTE_W-1:0] last_byte_q, last_byte_d;
  logic [BYTE_W-2:0] echo_q;
  logic              miso_q;
  logic              sclk_fall;

  assign sclk_fall   = ~sclk_s & sclk_d1_q;
  assign last_byte_d = accept ? shift_q : last_byte_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_byte_q <= '0;
      echo_q      <= '0;
      miso_q      <= 1'b0;
    end else begin
      if (state_q == DONE) last_byte_q <= last_byte_d;
      case (state_q)
        IDLE: begin
          if (csn_fall) begin
            miso_q <= last_byte_q[BYTE_W-1];
            echo_q <= last_byte_q[BYTE_W-2:0];
          end else begin
            miso_q <= 1'b0;
          end
        end
        SHIFT: begin
          // The trailing fall of the previous byte arrives with bit_cnt 0 and must not shift.
          if (csn_s || (sclk_rise && last_bit)) begin
            miso_q <= 1'b0;
          end else if (sclk_fall && bit_cnt_q != 3'd0) begin
            miso_q <= echo_q[BYTE_W-2];
            echo_q <= {echo_q[BYTE_W-3:0], 1'b0};
          end
        end
        DONE: begin
          if (!csn_s) begin
            miso_q <= last_byte_d[BYTE_W-1];
            echo_q <= last_byte_d[BYTE_W-2:0];
          end else begin
            miso_q <= 1'b0;
          end
        end
        default: miso_q <= 1'b0;
      endcase
    end
  end

  assign miso = miso_q;
`else
  assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_nibble_rx.sv
// tb/tb_spi_slave_nibble_rx.sv - scoreboard bench driving SPI frames at a 10:1 clock ratio
module tb_spi_slave_nibble_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       cs_n = 1'b1;
  logic       miso;
  logic [3:0] nibble;
  logic       byte_valid, cmd_err, frame_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit         is_frame;
    logic [3:0] nib;
    logic       cerr;
  } ev_t;

  ev_t exp_q[$];

  spi_slave_nibble_rx dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
    .miso(miso), .nibble(nibble), .byte_valid(byte_valid),
    .cmd_err(cmd_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_byte(input logic [3:0] nib, input logic cerr);
    ev_t e;
    e.is_frame = 1'b0; e.nib = nib; e.cerr = cerr;
    exp_q.push_back(e);
  endtask

  task automatic push_frame(input logic [3:0] nib);
    ev_t e;
    e.is_frame = 1'b1; e.nib = nib; e.cerr = 1'b0;
    exp_q.push_back(e);
  endtask

  // Mode 0 master: data set while sclk low, miso captured at the rising edge.
  task automatic xfer(input logic [7:0] b, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = b[7-i];
      clk_wait(5);
      sclk = 1'b1;
      rx = {rx[6:0], miso};
      clk_wait(5);
      sclk = 1'b0;
    end
  endtask

  task automatic chk_echo(input string name, input logic [7:0] rx, input logic [7:0] exp);
`ifdef MISO_ECHO_EN
    chk(name, {24'h0, rx}, {24'h0, exp});
`else
    chk(name, {24'h0, rx}, 32'h0);
`endif
  endtask

  task automatic frame1(input logic [7:0] b, input logic [7:0] echo_exp, input string name);
    logic [7:0] rx;
    cs_n = 1'b0;
    clk_wait(5);
    xfer(b, 8, rx);
    clk_wait(5);
    cs_n = 1'b1;
    clk_wait(10);
    chk_echo(name, rx, echo_exp);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_nibble"},     {28'h0, nibble}, 32'h0);
    chk({tag, "_byte_valid"}, {31'h0, byte_valid}, 32'h0);
    chk({tag, "_cmd_err"},    {31'h0, cmd_err}, 32'h0);
    chk({tag, "_frame_err"},  {31'h0, frame_err}, 32'h0);
    chk({tag, "_miso"},       {31'h0, miso}, 32'h0);
  endtask

  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst && (byte_valid || frame_err || cmd_err)) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event actual=bv%0b ce%0b fe%0b required=none", byte_valid, cmd_err, frame_err);
        end else begin
          e = exp_q.pop_front();
          chk("ev_byte_valid", {31'h0, byte_valid}, {31'h0, ~e.is_frame});
          chk("ev_frame_err",  {31'h0, frame_err},  {31'h0, e.is_frame});
          chk("ev_cmd_err",    {31'h0, cmd_err},    {31'h0, e.cerr});
          chk("ev_nibble",     {28'h0, nibble},     {28'h0, e.nib});
        end
      end
    end
  end

  initial begin : stimulus
    logic [7:0] rx, rx2;

    clk_wait(5);
    chk_reset_outputs("reset");
    rst = 1'b0;
    clk_wait(10);

    push_byte(4'h7, 1'b0);
    frame1(8'hA7, 8'h00, "echo_a7");

    push_byte(4'h7, 1'b1);
    frame1(8'h35, 8'hA7, "echo_35");

    push_frame(4'h7);
    cs_n = 1'b0;
    clk_wait(5);
    xfer(8'hA2, 5, rx);
    clk_wait(5);
    cs_n = 1'b1;
    clk_wait(10);
    chk("partial_nibble_hold", {28'h0, nibble}, 32'h7);

    push_byte(4'hC, 1'b0);
    frame1(8'hAC, 8'hA7, "echo_ac");

    push_byte(4'h1, 1'b0);
    push_byte(4'hF, 1'b0);
    cs_n = 1'b0;
    clk_wait(5);
    xfer(8'hA1, 8, rx);
    xfer(8'hAF, 8, rx2);
    clk_wait(5);
    cs_n = 1'b1;
    clk_wait(10);
    chk_echo("echo_b2b_first", rx, 8'hAC);
    chk_echo("echo_b2b_second", rx2, 8'hA1);
    chk("b2b_nibble", {28'h0, nibble}, 32'hF);

    cs_n = 1'b0;
    clk_wait(5);
    xfer(8'hA9, 4, rx);
    rst = 1'b1;
    clk_wait(1);
    chk_reset_outputs("midrst");
    cs_n = 1'b1;
    sclk = 1'b0;
    clk_wait(3);
    chk_reset_outputs("midrst_hold");
    rst = 1'b0;
    clk_wait(10);

    push_byte(4'h3, 1'b0);
    frame1(8'hA3, 8'h00, "echo_a3");

    push_byte(4'h5, 1'b0);
    frame1(8'hA5, 8'hA3, "echo_a5");

    push_byte(4'h5, 1'b1);
    frame1(8'h12, 8'hA5, "echo_readback_a5");

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'h0);
    chk("final_nibble", {28'h0, nibble}, 32'h5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
